// File: rtl/parametrik_bolme_birimi_if.sv
// Execute-stage divider handshake bundle.
//   master : pipeline side, drives stall/start/opcode/operands, reads result.
//   slave  : divider side.
//   durdur_i  stall from the stall controller, holds a finished result
//   basla_i   divide op present in the execute stage
//   islem_i   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   bolunen_i dividend, bolen_i divisor
//   sonuc_o   quotient/remainder, bitti_o result valid / ready, mesgul_o iterating
interface parametrik_bolme_birimi_if #(
  parameter int unsigned VERI_BIT = 32
);
  logic                durdur_i;
  logic                basla_i;
  logic [1:0]          islem_i;
  logic [VERI_BIT-1:0] bolunen_i;
  logic [VERI_BIT-1:0] bolen_i;
  logic [VERI_BIT-1:0] sonuc_o;
  logic                bitti_o;
  logic                mesgul_o;

  modport master (
    output durdur_i, basla_i, islem_i, bolunen_i, bolen_i,
    input  sonuc_o, bitti_o, mesgul_o
  );

  modport slave (
    input  durdur_i, basla_i, islem_i, bolunen_i, bolen_i,
    output sonuc_o, bitti_o, mesgul_o
  );
endinterface

// File: rtl/parametrik_bolme_birimi.sv
// Parametrised multi-cycle restoring integer divider with last-result cache.
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bolme  divider handshake bundle (slave side), see parametrik_bolme_birimi_if
// VERI_BIT must be a multiple of ADIM_BIT (1, 2 or 4). ONBELLEK=0 drops the cache.
module parametrik_bolme_birimi #(
  parameter int unsigned VERI_BIT = 32,
  parameter int unsigned ADIM_BIT = 1,
  parameter int unsigned ONBELLEK = 1
) (
  input logic                       clk_i,
  input logic                       rst_i,
  parametrik_bolme_birimi_if.slave  bolme
);

  localparam int unsigned N       = VERI_BIT / ADIM_BIT;
  localparam int unsigned SAYAC_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SAYAC_W-1:0]  SAYAC_SON = SAYAC_W'(N - 1);
  localparam logic [VERI_BIT-1:0] EN_KUCUK  = {1'b1, {(VERI_BIT-1){1'b0}}};

  typedef enum logic [1:0] {BOSTA, HESAPLA, DUZELT, BITTI} durum_t;

  durum_t durum_q, durum_d;

  // Working registers of the iteration
  logic [VERI_BIT-1:0] bolum_q, kalan_q, bolen_q;
  logic                bolum_neg_q, kalan_neg_q;
  logic [SAYAC_W-1:0]  sayac_q;
  // Operands of the op in flight, committed to the cache tag only on completion
  logic [VERI_BIT-1:0] bek_bolunen_q, bek_bolen_q;
  logic                bek_isaretsiz_q;
  // Result registers double as cache data
  logic [VERI_BIT-1:0] sonuc_bolum_q, sonuc_kalan_q;
  logic [VERI_BIT-1:0] on_bolunen_q, on_bolen_q;
  logic                on_isaretsiz_q, on_gecerli_q;

  logic                isaretli, bolunen_neg, bolen_neg;
  logic [VERI_BIT-1:0] bolunen_mut, bolen_mut;
  logic                sifir_bolen, tasma, isabet;
  logic [VERI_BIT-1:0] adim_bolum, adim_kalan;
  logic [VERI_BIT:0]   deneme;
  logic [VERI_BIT-1:0] secili_sonuc;
  logic [VERI_BIT-1:0] sonuc;
  logic                bitti, mesgul;

  always_comb begin
    isaretli    = ~bolme.islem_i[0];
    bolunen_neg = isaretli & bolme.bolunen_i[VERI_BIT-1];
    bolen_neg   = isaretli & bolme.bolen_i[VERI_BIT-1];
    bolunen_mut = bolunen_neg ? (~bolme.bolunen_i + 1'b1) : bolme.bolunen_i;
    bolen_mut   = bolen_neg ? (~bolme.bolen_i + 1'b1) : bolme.bolen_i;
    sifir_bolen = (bolme.bolen_i == '0);
    tasma       = isaretli && (bolme.bolunen_i == EN_KUCUK) && (bolme.bolen_i == '1);
    isabet      = (ONBELLEK != 0) && on_gecerli_q &&
                  (bolme.bolunen_i == on_bolunen_q) && (bolme.bolen_i == on_bolen_q) &&
                  (bolme.islem_i[0] == on_isaretsiz_q);
    secili_sonuc = bolme.islem_i[1] ? sonuc_kalan_q : sonuc_bolum_q;
  end

  // ADIM_BIT restoring steps chained in one cycle; the dividend shifts out of
  // bolum's MSB while quotient bits shift into its LSB.
  always_comb begin
    adim_bolum = bolum_q;
    adim_kalan = kalan_q;
    deneme     = '0;
    for (int unsigned i = 0; i < ADIM_BIT; i++) begin
      deneme     = {adim_kalan, adim_bolum[VERI_BIT-1]};
      adim_bolum = {adim_bolum[VERI_BIT-2:0], 1'b0};
      if (deneme >= {1'b0, bolen_q}) begin
        deneme        = deneme - {1'b0, bolen_q};
        adim_bolum[0] = 1'b1;
      end
      adim_kalan = deneme[VERI_BIT-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  always_comb begin
    durum_d = durum_q;
    bitti   = ~bolme.basla_i;
    sonuc   = '0;
    mesgul  = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (bolme.basla_i) begin
          if (isabet) begin
            bitti = 1'b1;
            sonuc = secili_sonuc;
          end else if (sifir_bolen || tasma) begin
            durum_d = BITTI;
          end else begin
            durum_d = HESAPLA;
          end
        end
      end
      HESAPLA: begin
        mesgul = 1'b1;
        if (!bolme.basla_i)          durum_d = BOSTA;
        else if (sayac_q == SAYAC_SON) durum_d = DUZELT;
      end
      DUZELT: begin
        mesgul  = 1'b1;
        durum_d = bolme.basla_i ? BITTI : BOSTA;
      end
      BITTI: begin
        bitti = 1'b1;
        sonuc = secili_sonuc;
        if (!bolme.durdur_i) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      on_gecerli_q <= 1'b0;
      sayac_q      <= '0;
    end else begin
      if (durum_q == BOSTA && bolme.basla_i && !isabet) begin
        bek_bolunen_q   <= bolme.bolunen_i;
        bek_bolen_q     <= bolme.bolen_i;
        bek_isaretsiz_q <= bolme.islem_i[0];
        if (sifir_bolen || tasma) begin
          sonuc_bolum_q  <= sifir_bolen ? '1 : EN_KUCUK;
          sonuc_kalan_q  <= sifir_bolen ? bolme.bolunen_i : '0;
          on_bolunen_q   <= bolme.bolunen_i;
          on_bolen_q     <= bolme.bolen_i;
          on_isaretsiz_q <= bolme.islem_i[0];
          on_gecerli_q   <= (ONBELLEK != 0);
        end else begin
          bolum_q     <= bolunen_mut;
          kalan_q     <= '0;
          bolen_q     <= bolen_mut;
          bolum_neg_q <= bolunen_neg ^ bolen_neg;
          kalan_neg_q <= bolunen_neg;
          sayac_q     <= '0;
        end
      end
      if (durum_q == HESAPLA && bolme.basla_i) begin
        bolum_q <= adim_bolum;
        kalan_q <= adim_kalan;
        sayac_q <= sayac_q + 1'b1;
      end
      if (durum_q == DUZELT && bolme.basla_i) begin
        sonuc_bolum_q  <= bolum_neg_q ? (~bolum_q + 1'b1) : bolum_q;
        sonuc_kalan_q  <= kalan_neg_q ? (~kalan_q + 1'b1) : kalan_q;
        on_bolunen_q   <= bek_bolunen_q;
        on_bolen_q     <= bek_bolen_q;
        on_isaretsiz_q <= bek_isaretsiz_q;
        on_gecerli_q   <= (ONBELLEK != 0);
      end
    end
  end

  assign bolme.sonuc_o  = sonuc;
  assign bolme.bitti_o  = bitti;
  assign bolme.mesgul_o = mesgul;

endmodule

// File: tb/tb_parametrik_bolme_birimi.sv
// Directed bench: one divider built with ADIM_BIT=1 and one with ADIM_BIT=4,
// a shared stimulus set steered to whichever instance sec selects.
module tb_parametrik_bolme_birimi;

  logic        clk = 1'b0;
  logic        rst;
  logic        sec;
  logic        basla, durdur;
  logic [1:0]  islem;
  logic [31:0] bolunen, bolen;
  logic [31:0] sonuc;
  logic        bitti, mesgul;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  always #5 clk = ~clk;

  parametrik_bolme_birimi_if #(.VERI_BIT(32)) bif1 ();
  parametrik_bolme_birimi_if #(.VERI_BIT(32)) bif4 ();

  assign bif1.basla_i   = basla & ~sec;
  assign bif1.durdur_i  = durdur;
  assign bif1.islem_i   = islem;
  assign bif1.bolunen_i = bolunen;
  assign bif1.bolen_i   = bolen;
  assign bif4.basla_i   = basla & sec;
  assign bif4.durdur_i  = durdur;
  assign bif4.islem_i   = islem;
  assign bif4.bolunen_i = bolunen;
  assign bif4.bolen_i   = bolen;

  assign sonuc  = sec ? bif4.sonuc_o  : bif1.sonuc_o;
  assign bitti  = sec ? bif4.bitti_o  : bif1.bitti_o;
  assign mesgul = sec ? bif4.mesgul_o : bif1.mesgul_o;

  parametrik_bolme_birimi #(.VERI_BIT(32), .ADIM_BIT(1), .ONBELLEK(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bolme (bif1)
  );

  parametrik_bolme_birimi #(.VERI_BIT(32), .ADIM_BIT(4), .ONBELLEK(1)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bolme (bif4)
  );

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
    end
  endtask

  // Presents an op at the next cycle (cycle 0) and waits, bounded, for bitti.
  // Returns at the negedge of the cycle where bitti was seen.
  task automatic islem_calis(input string etiket, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input int bek_gec, input logic [31:0] bek_sonuc);
    int gec;
    gec = -1;
    @(posedge clk); #1;
    basla = 1'b1; islem = op; bolunen = a; bolen = b;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (bitti) begin
        gec = k;
        break;
      end
      @(posedge clk); #1;
    end
    kontrol({etiket, "/gecikme"}, 64'(gec), 64'(bek_gec));
    kontrol({etiket, "/sonuc"}, {32'h0, sonuc}, {32'h0, bek_sonuc});
  endtask

  initial begin
    rst = 1'b1; sec = 1'b0; basla = 1'b0; durdur = 1'b0;
    islem = DIVU; bolunen = '0; bolen = '0;
    @(posedge clk); #1;
    @(negedge clk);
    kontrol("reset/bitti",  {63'h0, bitti},  64'h1);
    kontrol("reset/sonuc",  {32'h0, sonuc},  64'h0);
    kontrol("reset/mesgul", {63'h0, mesgul}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADIM_BIT = 1 instance
    islem_calis("divu_100_7",  DIVU, 32'd100, 32'd7, 34, 32'd14);
    islem_calis("remu_100_7",  REMU, 32'd100, 32'd7, 0,  32'd2);
    islem_calis("div_m7_2",    DIV,  32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD);
    islem_calis("rem_m7_2",    REM,  32'hFFFFFFF9, 32'd2, 0,  32'hFFFFFFFF);
    islem_calis("divu_fff9_2", DIVU, 32'hFFFFFFF9, 32'd2, 34, 32'h7FFFFFFC);
    islem_calis("divu_5_0",    DIVU, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
    islem_calis("div_min_m1",  DIV,  32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    islem_calis("rem_5_0",     REM,  32'd5, 32'd0, 1, 32'd5);
    islem_calis("rem_min_m1",  REM,  32'h80000000, 32'hFFFFFFFF, 1, 32'd0);
    islem_calis("divu_1000_10", DIVU, 32'd1000, 32'd10, 34, 32'd100);

    // Stall holds the completed result
    durdur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      kontrol("durdur/bitti", {63'h0, bitti}, 64'h1);
      kontrol("durdur/sonuc", {32'h0, sonuc}, 64'd100);
    end
    durdur = 1'b0;
    // A non-cached op next cycle sees BOSTA: not ready, zero result
    @(posedge clk); #1;
    bolen = 32'd9;
    @(negedge clk);
    kontrol("birak/bitti", {63'h0, bitti}, 64'h0);
    kontrol("birak/sonuc", {32'h0, sonuc}, 64'h0);
    @(posedge clk); #1;
    basla = 1'b0;
    @(negedge clk);
    kontrol("iptal1/mesgul_hesapla", {63'h0, mesgul}, 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    kontrol("iptal1/mesgul_bosta", {63'h0, mesgul}, 64'h0);

    // Flush at cycle 10
    @(posedge clk); #1;
    basla = 1'b1; islem = DIVU; bolunen = 32'd50; bolen = 32'd3;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    kontrol("iptal2/mesgul_c9", {63'h0, mesgul}, 64'h1);
    @(posedge clk); #1;
    basla = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    kontrol("iptal2/mesgul_bosta", {63'h0, mesgul}, 64'h0);
    kontrol("iptal2/bitti_bosta",  {63'h0, bitti},  64'h1);
    islem_calis("iptal_sonrasi_remu_1000_10", REMU, 32'd1000, 32'd10, 0, 32'd0);
    islem_calis("divu_50_3", DIVU, 32'd50, 32'd3, 34, 32'd16);
    @(posedge clk); #1;
    basla = 1'b0;

    // ADIM_BIT = 4 instance
    sec = 1'b1;
    islem_calis("a4_divu_ffff_3", DIVU, 32'hFFFFFFFF, 32'd3, 10, 32'h55555555);
    islem_calis("a4_remu_ffff_3", REMU, 32'hFFFFFFFF, 32'd3, 0,  32'd0);
    islem_calis("a4_div_m100_7",  DIV,  32'hFFFFFF9C, 32'd7, 10, 32'hFFFFFFF2);
    islem_calis("a4_rem_m100_7",  REM,  32'hFFFFFF9C, 32'd7, 0,  32'hFFFFFFFE);

    // Reset at cycle 5 of a running op
    @(posedge clk); #1;
    basla = 1'b1; islem = DIVU; bolunen = 32'd1000; bolen = 32'd7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; basla = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    kontrol("a4_reset/mesgul", {63'h0, mesgul}, 64'h0);
    islem_calis("a4_reset_sonrasi_rem_m100_7", REM, 32'hFFFFFF9C, 32'd7, 10, 32'hFFFFFFFE);
    islem_calis("a4_divu_1000_7", DIVU, 32'd1000, 32'd7, 10, 32'd142);
    @(posedge clk); #1;
    basla = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

endmodule
